// File: rtl/array_dot_acc.sv
// array_dot_acc: pipelined dot-product engine.
// Each beat carries LANES element pairs. The beat goes through one
// registered multiply stage (M), then log2(LANES) registered adder-tree
// levels (T1..Tk), then the cross-beat accumulator / output stage (A).
// When in_last is set on a beat, the vector's sum and its beat count are
// written to the output register.
// Optional build macro ARRAY_DOT_SIGNED_EN: operands are two's-complement
// and products are sign-extended. Without it, operands are unsigned and
// products are zero-extended. Latency is the same in both builds.
module array_dot_acc #(
  parameter int LANES  = 8,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int BEAT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LANES*DATA_W-1:0] in_a,
  input  logic [LANES*DATA_W-1:0] in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_data,
  output logic [BEAT_W-1:0]       out_beats
);

  // Tree depth and node count. The leaves hold the M-stage products and
  // the root holds the Tk sum. Node n has children 2n+1 and 2n+2, so each
  // heap level is exactly one pipeline stage.
  localparam int K     = $clog2(LANES);
  localparam int NODES = 2 * LANES - 1;
  // The multiply runs wide enough to hold the full 2*DATA_W product and
  // the ACC_W result. Truncating this to ACC_W bits gives the same value
  // as extending or truncating the full product.
  localparam int XW    = (ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W;

  logic              adv;
  logic [ACC_W-1:0]  prod [LANES];
  logic [ACC_W-1:0]  node [NODES];
  logic [K:0]        vld;
  logic [K:0]        lst;
  logic [ACC_W-1:0]  acc;
  logic [BEAT_W-1:0] cnt;

  // NOTE: in_ready comes combinationally from the output register state.
  // A consumer that takes the result in this cycle unstalls the whole
  // pipeline in the same cycle, so back-to-back throughput is kept.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // Per-lane products, extended or truncated to ACC_W
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
`ifdef ARRAY_DOT_SIGNED_EN
      prod[i] = ACC_W'(XW'($signed(in_a[i*DATA_W +: DATA_W])) *
                       XW'($signed(in_b[i*DATA_W +: DATA_W])));
`else
      prod[i] = ACC_W'(XW'(in_a[i*DATA_W +: DATA_W]) *
                       XW'(in_b[i*DATA_W +: DATA_W]));
`endif
    end
  end

  // Stage valid/last shift register, one bit per pipeline stage M..Tk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
    end else if (adv) begin
      vld <= {vld[K-1:0], in_valid};
      lst <= {lst[K-1:0], in_valid && in_last};
    end
  end

  // Datapath: the leaves capture products on a handshake, and each inner
  // node adds its two children
  // NOTE: the tree registers are not reset. Their contents matter only
  // where the matching vld bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) begin
          node[LANES-1+i] <= prod[i];
        end
      end
      for (int n = 0; n < LANES - 1; n++) begin
        node[n] <= node[2*n+1] + node[2*n+2];
      end
    end
  end

  // Cross-beat accumulator and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else if (adv) begin
      // With adv=1 the old result is either absent or consumed this cycle.
      out_valid <= vld[K] && lst[K];
      if (vld[K]) begin
        if (lst[K]) begin
          out_data  <= acc + node[0];
          out_beats <= cnt + BEAT_W'(1);
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc + node[0];
          cnt <= cnt + BEAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_array_dot_acc.sv
// Testbench for array_dot_acc: table-driven single-beat vectors and
// hand-written multi-beat, backpressure, reset and back-to-back sequences.
// A second instance with ACC_W=64 shares the inputs and shows the
// full-width and sign-extension behaviour.
module tb_array_dot_acc;

  localparam int LANES  = 8;
  localparam int DATA_W = 32;
  localparam int LW     = LANES * DATA_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_ready64;
  logic          in_last;
  logic [LW-1:0] in_a;
  logic [LW-1:0] in_b;
  logic          out_valid;
  logic          out_valid64;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [63:0]   out_data64;
  logic [15:0]   out_beats;
  logic [15:0]   out_beats64;

  int checks = 0;
  int errors = 0;
  logic [63:0] got_d [$];
  int          got_t [$];

  typedef struct {
    string         name;
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic [31:0]   exp32;
    logic [63:0]   exp64;
  } vec_t;

  vec_t tbl [6];

  array_dot_acc #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(32), .BEAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beats(out_beats)
  );

  array_dot_acc #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(64), .BEAT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready64), .in_last(in_last),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_data(out_data64), .out_beats(out_beats64)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] fill(input logic [31:0] v);
    logic [LW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = v;
    return r;
  endfunction

  function automatic logic [LW-1:0] ramp();
    logic [LW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = 32'(i + 1);
    return r;
  endfunction

  function automatic logic [LW-1:0] lane0(input logic [31:0] v);
    logic [LW-1:0] r;
    r = '0;
    r[31:0] = v;
    return r;
  endfunction

  // Offers one beat from a negedge and returns at the negedge after it
  // was accepted. Afterwards it drives junk, which must be ignored.
  task automatic send(input logic [LW-1:0] a, input logic [LW-1:0] b, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = '1;
    in_b     = '1;
    in_last  = 1'b1;
  endtask

  // Counts negedges since the accepting posedge until out_valid goes high.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
  endtask

  task automatic collect(input int n);
    got_d.delete();
    got_t.delete();
    for (int i = 0; i < n; i++) begin
      if (out_valid) begin
        got_d.push_back(64'(out_data));
        got_t.push_back(i);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;

    tbl[0] = '{"ramp_x2", ramp(), fill(32'd2), 32'd72, 64'd72};
`ifdef ARRAY_DOT_SIGNED_EN
    tbl[1] = '{"allones_x1", fill(32'hFFFF_FFFF), fill(32'd1), 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8};
    tbl[2] = '{"lane0_max_x2", lane0(32'hFFFF_FFFF), lane0(32'd2), 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE};
`else
    tbl[1] = '{"allones_x1", fill(32'hFFFF_FFFF), fill(32'd1), 32'hFFFF_FFF8, 64'h0000_0007_FFFF_FFF8};
    tbl[2] = '{"lane0_max_x2", lane0(32'hFFFF_FFFF), lane0(32'd2), 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFE};
`endif
    tbl[3] = '{"wrap_2p32", fill(32'h0001_0000), fill(32'h0001_0000), 32'd0, 64'h0000_0008_0000_0000};
    tbl[4] = '{"squares", ramp(), ramp(), 32'd204, 64'd204};
    tbl[5] = '{"zero_a", fill(32'd0), fill(32'h1234_5678), 32'd0, 64'd0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_beats", out_beats, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-beat vectors from the table
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].b, 1'b1);
      wait_out(lat);
      check({tbl[i].name, "_lat"}, 64'(lat), 5);
      check({tbl[i].name, "_data"}, out_data, tbl[i].exp32);
      check({tbl[i].name, "_beats"}, out_beats, 1);
      check({tbl[i].name, "_data64"}, out_data64, tbl[i].exp64);
      @(negedge clk);
      check({tbl[i].name, "_pulse"}, out_valid, 0);
    end

    // Three-beat vector: 3 x (8 x 1*3) = 72, exactly one result pulse
    send(fill(32'd1), fill(32'd3), 1'b0);
    send(fill(32'd1), fill(32'd3), 1'b0);
    send(fill(32'd1), fill(32'd3), 1'b1);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) begin
        pulses++;
        check("multi_data", out_data, 72);
        check("multi_beats", out_beats, 3);
      end
      @(negedge clk);
    end
    check("multi_pulses", 64'(pulses), 1);

    // Backpressure: the result (8) is held while the next beat is offered
    out_ready = 1'b0;
    send(fill(32'd1), fill(32'd1), 1'b1);
    wait_out(lat);
    in_valid = 1'b1;
    in_a     = fill(32'd2);
    in_b     = fill(32'd1);
    in_last  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_in_ready64", in_ready64, 0);
      check("bp_hold_data", out_data, 8);
      check("bp_hold_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_drain", out_valid, 0);
    send(fill(32'd3), fill(32'd1), 1'b1);
    collect(15);
    check("bp_count", 64'(got_d.size()), 2);
    check("bp_first", got_d[0], 16);
    check("bp_second", got_d[1], 24);

    // Back-to-back single-beat vectors: values 8*k, one result per cycle
    fork
      begin
        for (int k = 1; k <= 6; k++) send(fill(32'(k)), fill(32'd1), 1'b1);
      end
      begin
        collect(16);
      end
    join
    check("b2b_count", 64'(got_d.size()), 6);
    for (int j = 0; j < 6; j++) begin
      check("b2b_data", got_d[j], 64'(8 * (j + 1)));
      check("b2b_time", 64'(got_t[j]), 64'(5 + j));
    end

    // Reset mid-vector discards the partial sum and clears the outputs
    send(fill(32'd1), fill(32'd1), 1'b0);
    send(fill(32'd1), fill(32'd1), 1'b0);
    repeat (6) @(negedge clk);
    check("partial_no_out", out_valid, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_beats", out_beats, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(fill(32'd1), fill(32'd5), 1'b1);
    wait_out(lat);
    check("postrst_lat", 64'(lat), 5);
    check("postrst_data", out_data, 40);
    check("postrst_beats", out_beats, 1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_dot_acc.md
Name: array_dot_acc

Overview:
- Pipelined, parametrised dot-product engine: LANES element-wise multiplies per beat, registered adder tree, then a cross-beat accumulator.
- Vectors longer than one line stream in as multiple beats; in_last closes a vector and emits its sum plus a beat count.
- Sits between the cache-line read path and the result write-back path.
- Valid/ready on both sides; sustains one beat per cycle.

Parameters:
- LANES, 8, elements per beat; power of 2, >= 2.
- DATA_W, 32, element width in bits.
- ACC_W, 32, width of products, tree sums and accumulator; arithmetic is modulo 2^ACC_W.
- BEAT_W, 16, width of the per-vector beat counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_last  in  1  final beat of the current vector.
- in_a  in  LANES*DATA_W  operand A; lane i is bits [i*DATA_W +: DATA_W].
- in_b  in  LANES*DATA_W  operand B; same lane layout as in_a.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  ACC_W  dot product of the completed vector.
- out_beats  out  BEAT_W  number of beats in that vector, modulo 2^BEAT_W.

Behaviour:
- Reset: asynchronous assert clears all stage valids, the accumulator, the beat counter, out_valid, out_data and out_beats to 0. in_ready is 1 after reset.
- Pipeline advance: adv = !(out_valid && !out_ready); in_ready = adv. All stages, including bubbles, move only when adv=1. When adv=0 every register holds.
- Stage M (1 cycle): per lane, the full 2*DATA_W product, zero-extended (unsigned mode) to ACC_W or truncated to its low ACC_W bits; valid and last are registered alongside.
- Stages T1..Tk, k = log2(LANES): each is one registered pairwise-add level of width ACC_W, wrapping modulo 2^ACC_W.
- Stage A, when a valid beat arrives with sum S:
  - Not last: acc <= acc + S, cnt <= cnt + 1, no output.
  - Last: out_data <= acc + S, out_beats <= cnt + 1, out_valid <= 1, then acc <= 0 and cnt <= 0.
- Latency: last beat accepted in cycle t gives out_valid=1 in cycle t + 2 + log2(LANES), which is 5 for the defaults, provided no stall occurs.
- Output register: out_valid drops after a handshake unless a new result is written in the same cycle, in which case it stays 1 with the new data. out_data and out_beats are stable while out_valid && !out_ready.
- Boundaries:
  - A single-beat vector (in_last on its first beat) gives out_beats=1.
  - cnt wraps silently at 2^BEAT_W.
  - in_a/in_b are sampled only on a handshake; values while in_valid=0 are ignored.
- Back-to-back: vectors end to end with out_ready held at 1 give one result per cycle; no cycle is lost between vectors.
- Reset mid-vector: the partial accumulation is discarded. The first vector after release contains only beats accepted after release.

Optional Feature:
- Macro: ARRAY_DOT_SIGNED_EN.
- Defined: operands are two's-complement; products are signed and sign-extended (or truncated) to ACC_W.
- Not defined: operands and products are unsigned, zero-extended to ACC_W.
- The pipeline structure and latency are identical in both builds.

Test Plan:
- Single beat, defaults: in_a lanes = 1..8, in_b lanes all 2, in_last=1 -> 5 cycles later out_data=72, out_beats=1.
- Multi-beat: 3 beats, in_a all 1, in_b all 3, in_last on beat 3 -> out_data=72, out_beats=3; exactly one out_valid pulse.
- Backpressure: result pending with out_ready=0 for 4 cycles while new beats are offered -> in_ready=0, out_data held at its value, no beat lost; the next vectors' results appear in order once out_ready=1.
- Width and sign, ACC_W=64: lane0 a=0xFFFFFFFF, b=2, other lanes 0 -> out_data=0x00000001FFFFFFFE without ARRAY_DOT_SIGNED_EN, 0xFFFFFFFFFFFFFFFE with it.
- Reset mid-vector: 2 beats of all-1 x all-1 (no last), then rst_n pulsed low -> out_valid=0 immediately; then a 1-beat vector of all-1 x all-5 -> out_data=40, out_beats=1.
- Back-to-back: 6 single-beat vectors on consecutive cycles with out_ready=1 -> 6 results on consecutive cycles, first result 5 cycles after the first beat.
